// File: rtl/painel_pkg.sv
// Shared definitions for the panel scroll controller.
//   SEL_*   : select codes driven onto the shift register cells
//   state_e : sequencing states of the controller
package painel_pkg;

  localparam logic [1:0] SEL_LOAD = 2'b00;  // take parallel load_data
  localparam logic [1:0] SEL_UP   = 2'b01;  // take upper neighbour q[i+1]
  localparam logic [1:0] SEL_DN   = 2'b10;  // take lower neighbour q[i-1]
  localparam logic [1:0] SEL_HOLD = 2'b11;  // keep q[i]

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SCROLL = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/painel_scroll_ctrl_if.sv
// Command/status bundle between the panel command logic (master) and the
// scroll controller (slave).
//   master drives : start, load_data, dir, rotate, steps, pause, abort
//   slave drives  : sel, panel, busy, done, step_cnt, dbg_state
// Handshake: start is a one-cycle request that is accepted only while the
// controller is idle (busy=0 and done=0); a request at any other time is
// dropped, never queued. Acceptance is visible as busy rising on the next
// cycle, and completion as a single-cycle done pulse after busy falls.
interface painel_scroll_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 8
);

  logic                start;
  logic [WIDTH-1:0]    load_data;
  logic                dir;
  logic                rotate;
  logic [STEP_W-1:0]   steps;
  logic                pause;
  logic                abort;

  logic [1:0]          sel;
  logic [WIDTH-1:0]    panel;
  logic                busy;
  logic                done;
  logic [STEP_W-1:0]   step_cnt;
  painel_pkg::state_e  dbg_state;

  modport master (
    output start, load_data, dir, rotate, steps, pause, abort,
    input  sel, panel, busy, done, step_cnt, dbg_state
  );

  modport slave (
    input  start, load_data, dir, rotate, steps, pause, abort,
    output sel, panel, busy, done, step_cnt, dbg_state
  );

endinterface

// File: rtl/painel_scroll_tick.sv
// Scroll-rate prescaler: counts 0..DIV-1 while enabled and flags the last
// count as tick. Holds its count when en=0 so a paused scroll resumes in
// the same phase.
//   clk, reset_n : clock, async active-low reset
//   clr          : synchronous clear to 0 (priority over en)
//   en           : advance the count this cycle
//   tick         : count is at DIV-1
module painel_scroll_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/painel_scroll_ctrl.sv
// Panel scroll controller: owns the WIDTH-bit display register (one 4:1
// select cell per bit) and sequences the shared select code to load a
// pattern and scroll it by a programmed number of steps, one step every
// DIV enabled cycles, with pause, abort and rotate/zero-fill options.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : command inputs, sel/panel/busy/done/step_cnt status,
//                  dbg_state exposing the FSM state
module painel_scroll_ctrl
  import painel_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIV    = 4,
  parameter int STEP_W = 8
) (
  input logic                  clk,
  input logic                  reset_n,
  painel_scroll_ctrl_if.slave  bus
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    panel_q, panel_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic                dir_q, dir_d;
  logic                rotate_q, rotate_d;

  logic [1:0]          sel;
  logic [STEP_W-1:0]   step_inc;
  logic                presc_clr, presc_en, tick;

  painel_scroll_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (presc_clr),
    .en      (presc_en),
    .tick    (tick)
  );

  // Sequencer. abort overrides everything: back to IDLE with sel=HOLD, so
  // the register keeps whatever it was showing and no done pulse follows.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    rotate_d   = rotate_q;
    steps_d    = steps_q;
    step_cnt_d = step_cnt_q;
    sel        = SEL_HOLD;
    presc_clr  = 1'b0;
    presc_en   = 1'b0;
    step_inc   = step_cnt_q + STEP_W'(1);
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dir_d      = bus.dir;
            rotate_d   = bus.rotate;
            steps_d    = bus.steps;
            step_cnt_d = '0;
            presc_clr  = 1'b1;
            state_d    = LOAD;
          end
        end
        LOAD: begin
          sel     = SEL_LOAD;
          state_d = (steps_q == '0) ? DONE : SCROLL;
        end
        SCROLL: begin
          // pause freezes the prescaler, so tick is ignored while paused
          if (!bus.pause) begin
            presc_en = 1'b1;
            if (tick) begin
              sel        = dir_q ? SEL_UP : SEL_DN;
              step_cnt_d = step_inc;
              if (step_inc == steps_q) state_d = DONE;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Neighbour values seen by each cell; the vacated end bit takes the
  // opposite end when rotating, zero otherwise.
  logic [WIDTH-1:0] up_v, dn_v;
  assign up_v = {rotate_q & panel_q[0], panel_q[WIDTH-1:1]};
  assign dn_v = {panel_q[WIDTH-2:0], rotate_q & panel_q[WIDTH-1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign panel_d[i] = (sel == SEL_LOAD) ? bus.load_data[i] :
                        (sel == SEL_UP)   ? up_v[i]          :
                        (sel == SEL_DN)   ? dn_v[i]          :
                                            panel_q[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      panel_q    <= '0;
      step_cnt_q <= '0;
      steps_q    <= '0;
      dir_q      <= 1'b0;
      rotate_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      panel_q    <= panel_d;
      step_cnt_q <= step_cnt_d;
      steps_q    <= steps_d;
      dir_q      <= dir_d;
      rotate_q   <= rotate_d;
    end
  end

  assign bus.sel       = sel;
  assign bus.panel     = panel_q;
  assign bus.busy      = (state_q == LOAD) || (state_q == SCROLL);
  assign bus.done      = (state_q == DONE);
  assign bus.step_cnt  = step_cnt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: doc/painel_scroll_ctrl.md
Name: painel_scroll_ctrl

Overview:
Sequencing controller for the electronic panel's universal shift register. Owns a WIDTH-bit display register built from per-bit 4:1 select cells, and drives the shared select code to load, scroll and hold it. Loads a parallel pattern, then scrolls it left or right by a programmed number of steps at a prescaled rate, with pause, abort and fill/rotate options. Sits between the panel command logic and the LED column drivers.

Parameters:
WIDTH, 8, display register width in bits (>=2).
DIV, 4, clock cycles per scroll step (>=1).
STEP_W, 8, width of the step counter.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
load_data  in  WIDTH  pattern, captured into the register in the LOAD cycle.
dir  in  1  0 = shift toward MSB (q[i] <= q[i-1]); 1 = toward LSB (q[i] <= q[i+1]); latched at start.
rotate  in  1  1 = wrap the end bit; 0 = fill the vacated bit with 0; latched at start.
steps  in  STEP_W  number of scroll steps; latched at start.
pause  in  1  level; freezes scrolling while high.
abort  in  1  synchronous return to IDLE; the register holds its value.
sel  out  2  {s1,s0} select applied at the next edge: 00 load, 01 from upper neighbour, 10 from lower neighbour, 11 hold.
panel  out  WIDTH  display register contents.
busy  out  1  high in LOAD and SCROLL.
done  out  1  one-cycle pulse when the sequence completes.
step_cnt  out  STEP_W  steps completed in the current sequence.

Behaviour:
- Reset (async, reset_n=0): state IDLE, panel=0, sel=11, busy=0, done=0, step_cnt=0, prescaler=0. Release is synchronous to clk.
- Select semantics per bit i: 00 -> load_data[i]; 01 -> q[i+1]; 10 -> q[i-1]; 11 -> q[i].
- End bits: q[WIDTH] is q[0] if rotate, else 0. q[-1] is q[WIDTH-1] if rotate, else 0.
- sel is combinational from state and tick. panel updates on the same edge.
- IDLE: sel=11. If start=1, latch dir, rotate and steps; clear step_cnt and prescaler; go to LOAD.
- LOAD (1 cycle): sel=00 and panel<=load_data. If steps==0, go to DONE, otherwise go to SCROLL.
- SCROLL:
  - The prescaler counts 0..DIV-1, and tick = (prescaler==DIV-1).
  - On a tick, sel = dir ? 01 : 10, step_cnt increments, and the prescaler wraps to 0.
  - If the incremented step_cnt equals steps, go to DONE.
  - On non-tick cycles, sel=11.
- PAUSE: pause=1 in SCROLL freezes the prescaler and forces sel=11 with no step. Resuming continues the prescaler from its frozen value. pause has no effect in other states.
- DONE (1 cycle): done=1, sel=11, busy=0, then IDLE. step_cnt holds its final value until the next start.
- Latency: for a start sampled at edge k, the load happens at edge k+1 and the last shift at edge k+1+steps*DIV. done is high during the following cycle.
- start outside IDLE is ignored. No queueing.
- abort has priority over pause and tick in every state. Next state is IDLE, sel=11 in the abort cycle, panel unchanged, no done pulse.
- Simultaneous start and abort in IDLE: abort wins, stay IDLE.
- DIV=1: one step every SCROLL cycle.
- Reset asserted mid-sequence clears everything immediately, including panel.

Decomposition:
- Shared package painel_pkg:
  - sel encodings SEL_LOAD=2'b00, SEL_UP=2'b01, SEL_DN=2'b10, SEL_HOLD=2'b11;
  - state enum {IDLE, LOAD, SCROLL, DONE}.
- One sub-module, painel_scroll_tick: the DIV prescaler with enable (pause), clear and tick output.
- The select cells and register stay in the top as a generate loop.

Test Plan:
1. Reset values: hold reset_n=0 mid-SCROLL -> panel=0, sel=11, busy=0, done=0 immediately, asynchronously.
2. Rotate toward MSB: WIDTH=8, DIV=2, load 8'b1000_0001, dir=0, rotate=1, steps=3 -> panel 0000_0011, 0000_0110, 0000_1100 at 2-cycle spacing. done pulses 8 cycles after the start edge, step_cnt=3.
3. Fill toward LSB: load 8'b1000_0001, dir=1, rotate=0, steps=2 -> panel 0100_0000 then 0010_0000. sel shows 01 only on tick cycles.
4. Pause: same as test 2 with pause held for 5 cycles after the first shift -> sel=11 and panel frozen during the pause. Remaining shifts follow with prescaler phase preserved; done is delayed by exactly 5 cycles.
5. Abort and busy start: start during SCROLL is ignored. abort after step 1 -> IDLE next cycle, panel stays 0000_0011, no done pulse.
6. steps=0: start with load_data=8'hA5 -> panel=A5 after LOAD, done the next cycle, no shift sel ever issued.
